// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: fetches bytes from an upstream FIFO and serialises them LSB first
// with one start bit and one stop bit. The line idles high.
// Optional build macro FIFO_UART_TX_PARITY_EN inserts an even-parity bit between
// the last data bit and the stop bit.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line high, waiting for en=1 and a non-empty FIFO
// REQ    | fifo_rd high for this one cycle
// WAIT   | FIFO read data becomes valid; captured at the exit edge
// START  | start bit (0), CLKS_PER_BIT cycles
// DATA   | 8 data bits, LSB first, CLKS_PER_BIT cycles each
// PARITY | even parity of the data byte (FIFO_UART_TX_PARITY_EN only)
// STOP   | stop bit (1); frame_cnt increments at the exit edge
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_data,
  output logic             fifo_rd,
  output logic             tx,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY = 3'd5,
`endif
    STOP   = 3'd6
  } state_t;

  // Bit timer is a down-counter; the terminal count (0) marks each bit boundary.
  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state;
  state_t      state_next;
  logic [7:0]  shreg;
  logic [2:0]  bit_idx;
  logic [15:0] bit_cnt;
  logic        bit_done;
`ifdef FIFO_UART_TX_PARITY_EN
  logic        par_bit;
`endif

  assign bit_done = (bit_cnt == 16'd0);

  // State register.
  always_ff @(posedge clock) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic plus line level and busy, decoded from the current state.
  always_comb begin
    state_next = state;
    tx         = 1'b1;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (en && !fifo_empty) state_next = REQ;
      end
      REQ:  state_next = WAIT;
      WAIT: state_next = START;
      START: begin
        tx = 1'b0;
        if (bit_done) state_next = DATA;
      end
      DATA: begin
        tx = shreg[0];
`ifdef FIFO_UART_TX_PARITY_EN
        if (bit_done && bit_idx == 3'd7) state_next = PARITY;
`else
        if (bit_done && bit_idx == 3'd7) state_next = STOP;
`endif
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        tx = par_bit;
        if (bit_done) state_next = STOP;
      end
`endif
      STOP: begin
        if (bit_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Read strobe is registered: it rises on the IDLE->REQ edge and covers only REQ.
  always_ff @(posedge clock) begin
    if (rst) fifo_rd <= 1'b0;
    else     fifo_rd <= (state_next == REQ);
  end

  // Bit timer: loaded while waiting for data, reloaded at every bit boundary.
  always_ff @(posedge clock) begin
    if (rst)                                bit_cnt <= 16'd0;
    else if (state == IDLE || state == REQ) bit_cnt <= 16'd0;
    else if (state == WAIT)                 bit_cnt <= BIT_LAST;
    else if (bit_done)                      bit_cnt <= BIT_LAST;
    else                                    bit_cnt <= bit_cnt - 16'd1;
  end

  // Byte capture, shifting, bit index, parity and completed-frame count.
  always_ff @(posedge clock) begin
    if (rst) begin
      shreg     <= 8'd0;
      bit_idx   <= 3'd0;
      frame_cnt <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      if (state == WAIT) begin
        shreg   <= fifo_data;
        bit_idx <= 3'd0;
`ifdef FIFO_UART_TX_PARITY_EN
        par_bit <= ^fifo_data;
`endif
      end else if (state == DATA && bit_done) begin
        shreg   <= {1'b0, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      if (state == STOP && bit_done) frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: drives fifo_uart_tx from a queue-backed FIFO and compares every
// cycle against a frame-position reference model; a mid-bit UART receiver decodes
// the line independently. A second instance (CNT_W=4) checks counter wrap.
module tb_fifo_uart_tx;
  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int P   = FB * CPB + 3;
  localparam int W_P = FB * 2 + 3;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_rd, tx, busy;
  logic [15:0] frame_cnt;

  logic        en2 = 1'b0;
  logic        w_empty = 1'b0;
  logic [7:0]  w_data = 8'h55;
  logic        w_rd, w_tx, w_busy;
  logic [3:0]  w_cnt;

  int tests = 0;
  int failed = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clock(clock), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd(fifo_rd), .tx(tx), .busy(busy), .frame_cnt(frame_cnt));

  fifo_uart_tx #(.CLKS_PER_BIT(2), .CNT_W(4)) dut_w (
    .clock(clock), .rst(rst), .en(en2), .fifo_empty(w_empty), .fifo_data(w_data),
    .fifo_rd(w_rd), .tx(w_tx), .busy(w_busy), .frame_cnt(w_cnt));

  always #5 clock = ~clock;

  // Upstream FIFO: registered read data, empty flag updated on the clock.
  always @(posedge clock) begin
    if (fifo_rd && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
    fifo_empty <= (fifo_q.size() == 0);
  end

  // Reference model: m_k = cycles since the fetch strobe (-1 when idle).
  int         m_k = -1;
  int         m_frames = 0;
  logic [7:0] m_cur = 8'h00;
  always @(posedge clock) begin
    if (rst) begin
      m_k = -1;
      m_frames = 0;
    end else if (m_k >= 0) begin
      m_k++;
      if (m_k == 2 + FB * CPB) begin
        m_k = -1;
        m_frames++;
      end
    end else if (en && !fifo_empty) begin
      m_k = 0;
      if (exp_q.size() > 0) m_cur = exp_q.pop_front();
    end
  end

  function automatic logic m_tx();
    int b;
    if (m_k < 2) return 1'b1;
    b = (m_k - 2) / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[b-1];
    if (FB == 11 && b == 9) return ^m_cur;
    return 1'b1;
  endfunction

  function automatic logic [18:0] m_vec();
    return {m_tx(), m_k >= 0, m_k == 0, 16'(m_frames)};
  endfunction

  // Independent receiver: samples the middle of every bit.
  logic       rx_on = 1'b0;
  logic       rx_prev = 1'b1;
  int         rx_t = 0;
  int         rx_perr = 0;
  int         rx_ferr = 0;
  logic [7:0] rx_sh = 8'h00;
  always @(negedge clock) begin
    int bn;
    if (rst) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (tx == 1'b0 && rx_prev == 1'b1) begin
        rx_on = 1'b1;
        rx_t  = 0;
      end
    end else begin
      rx_t++;
      if (rx_t % CPB == CPB / 2) begin
        bn = rx_t / CPB;
        if (bn >= 1 && bn <= 8) rx_sh[bn-1] = tx;
        else if (bn == FB - 1) begin
          rx_q.push_back(rx_sh);
          if (tx !== 1'b1) rx_ferr++;
          rx_on = 1'b0;
        end else if (bn == 9) begin
          if (tx !== ^rx_sh) rx_perr++;
        end
      end
    end
    rx_prev = tx;
  end

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    tests++; if (tx !== 1'b1) begin failed++; $display("FAIL reset_tx got %b expected 1", tx); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy got %b expected 0", busy); end
    tests++; if (fifo_rd !== 1'b0) begin failed++; $display("FAIL reset_rd got %b expected 0", fifo_rd); end
    tests++; if (frame_cnt !== 16'd0) begin failed++; $display("FAIL reset_cnt got %0d expected 0", frame_cnt); end
    tests++; if (w_cnt !== 4'd0) begin failed++; $display("FAIL reset_wcnt got %0d expected 0", w_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_single_byte();
    int np = 0;
    int base = rx_q.size();
    push_byte(8'hA5);
    en = 1'b1;
    for (int c = 0; c < P + 10; c++) begin
      @(negedge clock);
      if (fifo_rd) np++;
      tests++;
      if ({tx, busy, fifo_rd, frame_cnt} !== m_vec()) begin
        failed++; $display("FAIL single cycle %0d got %h expected %h", c, {tx, busy, fifo_rd, frame_cnt}, m_vec());
      end
    end
    tests++; if (np != 1) begin failed++; $display("FAIL single_pulses got %0d expected 1", np); end
    tests++; if (rx_q.size() != base + 1 || rx_q[rx_q.size()-1] !== 8'hA5) begin
      failed++; $display("FAIL single_rx got %0d bytes expected A5", rx_q.size() - base); end
    tests++; if (frame_cnt !== 16'd1) begin failed++; $display("FAIL single_cnt got %0d expected 1", frame_cnt); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL single_busy got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    int np = 0;
    int pt[3];
    int base = rx_q.size();
    logic [7:0] bytes[3];
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h3C;
    for (int i = 0; i < 3; i++) push_byte(bytes[i]);
    for (int c = 0; c < 3 * P + 15; c++) begin
      @(negedge clock);
      if (fifo_rd) begin
        if (np < 3) pt[np] = c;
        np++;
      end
      tests++;
      if ({tx, busy, fifo_rd, frame_cnt} !== m_vec()) begin
        failed++; $display("FAIL burst cycle %0d got %h expected %h", c, {tx, busy, fifo_rd, frame_cnt}, m_vec());
      end
    end
    tests++; if (np != 3) begin failed++; $display("FAIL burst_pulses got %0d expected 3", np); end
    else begin
      for (int i = 1; i < 3; i++) begin
        tests++;
        if (pt[i] - pt[i-1] != P) begin failed++; $display("FAIL burst_spacing got %0d expected %0d", pt[i] - pt[i-1], P); end
      end
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (rx_q.size() <= base + i || rx_q[base+i] !== bytes[i]) begin
        failed++; $display("FAIL burst_rx%0d got size %0d expected %h", i, rx_q.size() - base, bytes[i]);
      end
    end
    tests++; if (frame_cnt !== 16'd4) begin failed++; $display("FAIL burst_cnt got %0d expected 4", frame_cnt); end
  endtask

  task automatic test_empty();
    logic saw_rd = 1'b0;
    logic saw_low = 1'b0;
    logic saw_busy = 1'b0;
    en = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (fifo_rd) saw_rd = 1'b1;
      if (tx !== 1'b1) saw_low = 1'b1;
      if (busy !== 1'b0) saw_busy = 1'b1;
    end
    tests++; if (saw_rd) begin failed++; $display("FAIL empty_rd got 1 expected 0"); end
    tests++; if (saw_low) begin failed++; $display("FAIL empty_tx got 0 expected constant 1"); end
    tests++; if (saw_busy) begin failed++; $display("FAIL empty_busy got 1 expected 0"); end
  endtask

  task automatic test_enable_drop();
    int np = 0;
    int k_drop = -1;
    int base = rx_q.size();
    push_byte(8'h5A); push_byte(8'h11); push_byte(8'h22);
    en = 1'b1;
    for (int c = 0; c < 3 * P + 60; c++) begin
      @(negedge clock);
      if (fifo_rd) begin
        np++;
        if (np == 1) k_drop = c + 2 + 3 * CPB + 1;
      end
      tests++;
      if ({tx, busy, fifo_rd, frame_cnt} !== m_vec()) begin
        failed++; $display("FAIL endrop cycle %0d got %h expected %h", c, {tx, busy, fifo_rd, frame_cnt}, m_vec());
      end
      if (c == k_drop) en = 1'b0;
      if (k_drop >= 0 && c == k_drop + P + 10) begin
        tests++; if (np != 1) begin failed++; $display("FAIL endrop_pulses got %0d expected 1", np); end
        tests++; if (frame_cnt !== 16'd5) begin failed++; $display("FAIL endrop_cnt got %0d expected 5", frame_cnt); end
        tests++; if (rx_q.size() != base + 1 || rx_q[base] !== 8'h5A) begin
          failed++; $display("FAIL endrop_rx got %0d bytes expected 5A", rx_q.size() - base); end
        en = 1'b1;
      end
    end
    tests++; if (np != 3) begin failed++; $display("FAIL endrop_resume got %0d pulses expected 3", np); end
    tests++; if (rx_q.size() != base + 3 || rx_q[base+1] !== 8'h11 || rx_q[base+2] !== 8'h22) begin
      failed++; $display("FAIL endrop_rx_resume got %0d bytes expected 3", rx_q.size() - base); end
    tests++; if (frame_cnt !== 16'd7) begin failed++; $display("FAIL endrop_cnt_end got %0d expected 7", frame_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    int np = 0;
    int k_rst = -1;
    int base = rx_q.size();
    push_byte(8'h81); push_byte(8'h42);
    en = 1'b1;
    for (int c = 0; c < 2 * P + 30; c++) begin
      @(negedge clock);
      if (fifo_rd) begin
        np++;
        if (np == 1) k_rst = c + 2 + 5 * CPB + 1;
      end
      tests++;
      if ({tx, busy, fifo_rd, frame_cnt} !== m_vec()) begin
        failed++; $display("FAIL rstmid cycle %0d got %h expected %h", c, {tx, busy, fifo_rd, frame_cnt}, m_vec());
      end
      if (c == k_rst) rst = 1'b1;
      if (k_rst >= 0 && c == k_rst + 1) begin
        tests++; if ({tx, busy, frame_cnt} !== {1'b1, 1'b0, 16'd0}) begin
          failed++; $display("FAIL rstmid_after got tx=%b busy=%b cnt=%0d expected 1 0 0", tx, busy, frame_cnt); end
        rst = 1'b0;
      end
    end
    tests++; if (np != 2) begin failed++; $display("FAIL rstmid_pulses got %0d expected 2", np); end
    tests++; if (rx_q.size() != base + 1 || rx_q[rx_q.size()-1] !== 8'h42) begin
      failed++; $display("FAIL rstmid_rx got %0d bytes expected only 42", rx_q.size() - base); end
    tests++; if (frame_cnt !== 16'd1) begin failed++; $display("FAIL rstmid_cnt got %0d expected 1", frame_cnt); end
  endtask

  task automatic test_random();
    logic [7:0] sent[$];
    int base = rx_q.size();
    logic [7:0] b;
    for (int c = 0; c < 24 * P; c++) begin
      @(negedge clock);
      tests++;
      if ({tx, busy, fifo_rd, frame_cnt} !== m_vec()) begin
        failed++; $display("FAIL random cycle %0d got %h expected %h", c, {tx, busy, fifo_rd, frame_cnt}, m_vec());
      end
      if (c < 12 * P) begin
        if ($urandom_range(0, 7) == 0) en = ~en;
        if (sent.size() < 10 && $urandom_range(0, 15) == 0) begin
          b = 8'($urandom);
          sent.push_back(b);
          push_byte(b);
        end
      end else begin
        en = 1'b1;
        if (sent.size() < 10) begin
          b = 8'($urandom);
          sent.push_back(b);
          push_byte(b);
        end
      end
    end
    tests++; if (rx_q.size() != base + 10) begin failed++; $display("FAIL random_count got %0d expected 10", rx_q.size() - base); end
    else begin
      for (int i = 0; i < 10; i++) begin
        tests++;
        if (rx_q[base+i] !== sent[i]) begin failed++; $display("FAIL random_rx%0d got %h expected %h", i, rx_q[base+i], sent[i]); end
      end
    end
    tests++; if (frame_cnt !== 16'd11) begin failed++; $display("FAIL random_cnt got %0d expected 11", frame_cnt); end
    tests++; if (rx_perr != 0 || rx_ferr != 0) begin
      failed++; $display("FAIL line_errors got parity=%0d framing=%0d expected 0 0", rx_perr, rx_ferr); end
  endtask

  task automatic test_counter_wrap();
    int np = 0;
    en2 = 1'b1;
    for (int c = 0; c < 17 * W_P + 60; c++) begin
      @(negedge clock);
      if (w_rd) np++;
      if (np == 17) break;
    end
    en2 = 1'b0;
    for (int c = 0; c < 3 * W_P; c++) begin
      @(negedge clock);
      if (w_rd) np++;
      if (!w_busy) break;
    end
    tests++; if (np != 17) begin failed++; $display("FAIL wrap_pulses got %0d expected 17", np); end
    tests++; if (w_busy !== 1'b0) begin failed++; $display("FAIL wrap_busy got %b expected 0", w_busy); end
    tests++; if (w_cnt !== 4'd1) begin failed++; $display("FAIL wrap_cnt got %0d expected 1", w_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_empty();
    test_enable_drop();
    test_reset_mid_frame();
    test_random();
    test_counter_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4: clock cycles per serial bit; legal range 2..65535.
REQ-002 Parameter CNT_W, default 16: width of the frame counter.
REQ-003 clock  input  1  rising-edge system clock, shared with the upstream FIFO.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  transmit enable; gates only the start of a new fetch.
REQ-006 fifo_empty  input  1  empty flag from the upstream FIFO.
REQ-007 fifo_data  input  8  upstream FIFO registered read data; valid the cycle after a read is sampled.
REQ-008 fifo_rd  output  1  read strobe to the FIFO; registered, one-cycle pulse per byte.
REQ-009 tx  output  1  serial line; idles high.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 frame_cnt  output  CNT_W  count of completed frames; wraps modulo 2^CNT_W.

Function
REQ-012 The FSM states SHALL be IDLE, REQ, WAIT, START, DATA, PARITY, STOP; PARITY exists only per REQ-026.
REQ-013 IDLE -> REQ when en=1 and fifo_empty=0 at a clock edge; fifo_rd SHALL be 1 for exactly the REQ cycle.
REQ-014 REQ -> WAIT unconditionally; fifo_rd SHALL be 0 in WAIT.
REQ-015 At the WAIT->START edge, fifo_data SHALL be captured into an 8-bit shift register; fifo_data SHALL be ignored at all other times.
REQ-016 tx SHALL be 1 in IDLE, REQ and WAIT; 0 in START; shift-register bit 0 in DATA (LSB first); 1 in STOP.
REQ-017 START, each DATA bit, PARITY and STOP SHALL each last exactly CLKS_PER_BIT cycles, timed by a cycle counter that reloads on every bit boundary.
REQ-018 DATA SHALL emit exactly 8 bits, tracked by a 3-bit index; the shift register shifts right at each bit boundary.
REQ-019 At the STOP-end edge, frame_cnt SHALL increment by 1 and the FSM SHALL return to IDLE.
REQ-020 Back-to-back frames: with the FIFO non-empty, the next fifo_rd pulse SHALL occur exactly one cycle after returning to IDLE; the inter-frame gap is fixed at 3 idle-high cycles.
REQ-021 en falling mid-frame SHALL NOT abort the frame; the current frame completes and no further fetch starts.
REQ-022 fifo_empty rising after REQ SHALL NOT affect the frame in progress.
REQ-023 fifo_rd SHALL never be asserted while fifo_empty=1 was sampled in the same IDLE cycle.

Reset
REQ-024 rst=1 at an edge SHALL force state=IDLE, tx=1, fifo_rd=0, busy=0, frame_cnt=0, and shift register, bit index and cycle counter to 0.
REQ-025 Reset mid-frame SHALL take effect at that edge, truncating the frame; no frame_cnt increment; the next frame starts with a fresh fetch.

Configuration
REQ-026 Macro FIFO_UART_TX_PARITY_EN:
- Defined: a PARITY state is inserted between DATA and STOP; tx = XOR of the 8 data bits (even parity); frame = 11 bits, and the inter-frame period is 11*CLKS_PER_BIT+3 cycles.
- Undefined: no PARITY state or parity logic; frame = 10 bits, and the period is 10*CLKS_PER_BIT+3 cycles.

Verification
REQ-027 Single byte: CLKS_PER_BIT=4, FIFO holds 0xA5, en=1 -> one fifo_rd pulse; tx = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (plus parity 0 before the stop bit if FIFO_UART_TX_PARITY_EN); frame_cnt=1; busy low afterwards.
REQ-028 Burst: FIFO holds 0x00,0xFF,0x3C -> 3 fifo_rd pulses spaced exactly 10*4+3=43 cycles apart (47 with parity); decoded bytes in order; frame_cnt=3.
REQ-029 Empty FIFO: fifo_empty=1 for 200 cycles, en=1 -> fifo_rd never asserted, tx constant 1, busy 0.
REQ-030 Enable drop: en deasserted during DATA bit 2 of 0x5A, FIFO still non-empty -> 0x5A completes; no further fifo_rd; frame_cnt=1; re-raising en resumes fetching.
REQ-031 Reset mid-frame: rst pulsed during DATA bit 4 of 0x81 -> next cycle tx=1, busy=0, frame_cnt=0; the next byte 0x42 transmits intact.
REQ-032 Counter wrap: CNT_W=4, 17 frames -> frame_cnt reads 1.
